// File: rtl/modulo_mult_serial_if.sv
// Request/result bundle for modulo_mult_serial.
// The requester connects to the master modport and the multiplier connects to the slave modport.
interface modulo_mult_serial_if #(
    parameter int WIDTH = 256
);
    logic             i_start;
    logic             i_mode;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] i_n;
    logic [WIDTH-1:0] o_result;
    logic             o_finish;
    logic             o_busy;

    modport master (
        output i_start, i_mode, i_a, i_b, i_n,
        input  o_result, o_finish, o_busy
    );

    modport slave (
        input  i_start, i_mode, i_a, i_b, i_n,
        output o_result, o_finish, o_busy
    );
endinterface

// File: rtl/modulo_mult_serial.sv
// Bit-serial modular multiplier: a*b mod N (MUL) or b*2^WIDTH mod N (PREP).
// Processes one multiplier bit per clock, LSB first, and takes WIDTH iterations per operation.
module modulo_mult_serial #(
    parameter int WIDTH = 256,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                 clk,
    input logic                 rst,
    modulo_mult_serial_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] t_q;
    logic [WIDTH-1:0] result_q;
    logic             mode_q;
    logic             finish_q;
    logic             busy_q;

    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   sum_mt;
    logic [WIDTH:0]   dbl_t;
    logic [WIDTH-1:0] m_d;
    logic [WIDTH-1:0] t_d;
    logic [WIDTH-1:0] t_init;
    logic             last_iter;

    // NOTE: every always_comb output is assigned on every pass, so no latch can be inferred.
    // Both compares use the full WIDTH+1-bit sums. Each subtraction is exact modulo 2^WIDTH
    // because the reduced value always lies in [0, N-1].
    always_comb begin
        n_ext     = {1'b0, n_q};
        sum_mt    = {1'b0, m_q} + {1'b0, t_q};
        dbl_t     = {t_q, 1'b0};
        m_d       = m_q;
        if (!mode_q && a_q[0]) begin
            m_d = (sum_mt >= n_ext) ? (m_q + t_q - n_q) : (m_q + t_q);
        end
        t_d       = (dbl_t >= n_ext) ? ((t_q << 1) - n_q) : (t_q << 1);
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));

        // A zero modulus starts t at 0, so both modes finish with a zero result.
        if (bus.i_n == '0) begin
            t_init = '0;
        end else if (bus.i_b >= bus.i_n) begin
            t_init = bus.i_b - bus.i_n;
        end else begin
            t_init = bus.i_b;
        end
    end

    // NOTE: non-blocking assignments, so every register in this block sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            n_q      <= '0;
            m_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            mode_q   <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    finish_q <= 1'b0;
                    if (bus.i_start) begin
                        a_q     <= bus.i_a;
                        n_q     <= bus.i_n;
                        mode_q  <= bus.i_mode;
                        t_q     <= t_init;
                        m_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_q <= a_q >> 1;
                    m_q <= m_d;
                    t_q <= t_d;
                    if (last_iter) begin
                        result_q <= mode_q ? t_d : m_d;
                        finish_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_result = result_q;
    assign bus.o_finish = finish_q;
    assign bus.o_busy   = busy_q;

endmodule
